bht_port_scheduler: RTL and testbench

//  Sequences and arbitrates the gshare BHT (2^IDX_W x 2-bit counters, 1 sync-read + 1 write port).

---
 rtl/bht_port_scheduler.sv | 178 +++++++++++++++++
 tb/tb_bht_port_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_port_scheduler.sv
// Front end of the gshare BHT: sweeps the table after reset/flush, keeps the speculative GHR, and shares
// the single read port between ID predictions and queued EX read-modify-write counter updates.
module bht_port_scheduler #(
  parameter int         IDX_W      = 10,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_pred_req,
  input  logic [31:0]      i_pred_pc,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [IDX_W-1:0] o_pred_ghr,
  output logic [IDX_W-1:0] o_ghr,
  input  logic             i_upd_valid,
  input  logic [31:0]      i_upd_pc,
  input  logic [IDX_W-1:0] i_upd_ghr,
  input  logic             i_upd_taken,
  input  logic             i_upd_mispred,
  output logic             o_upd_ready,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_bht_ridx,
  input  logic [1:0]       i_bht_rdata,
  output logic             o_bht_we,
  output logic [IDX_W-1:0] o_bht_widx,
  output logic [1:0]       o_bht_wdata
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [IDX_W-1:0] pred_ghr_q, pred_ghr_d;
  logic             pend_q, pend_d;
  logic             pend_init_q, pend_init_d;
  logic [IDX_W-1:0] fifo_idx_q [FIFO_DEPTH];
  logic [IDX_W-1:0] fifo_idx_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_tkn_q, fifo_tkn_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_vld_q, w_vld_d, w_tkn_q, w_tkn_d, w_fwd_q, w_fwd_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [1:0]       last_wdata_q, last_wdata_d;

  logic             run, push, pop, pred_rd, w_we;
  logic [1:0]       w_old, w_new;
  logic [IDX_W-1:0] head_idx, upd_idx, pred_idx;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{i_pred_pc[31:IDX_W+2], i_pred_pc[1:0], i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};

  assign run      = (state_q == ST_RUN);
  assign upd_idx  = i_upd_pc[IDX_W+1:2] ^ i_upd_ghr;
  assign pred_idx = i_pred_pc[IDX_W+1:2] ^ ghr_q;
  assign head_idx = fifo_idx_q[rd_ptr_q];

  // Predictions own the read port; the update queue only drains in idle read slots.
  assign o_upd_ready = run & (cnt_q != FULL_CNT);
  assign push        = i_upd_valid & o_upd_ready & ~i_flush;
  assign pred_rd     = run & i_pred_req & ~i_flush;
  assign pop         = run & ~i_pred_req & (cnt_q != '0) & ~i_flush;
  assign w_we        = w_vld_q & ~i_flush;

  // RAM read of an index being written this same cycle returns stale data, so take the in-flight value.
  always_comb begin
    w_old = w_fwd_q ? last_wdata_q : i_bht_rdata;
    w_new = w_old;
    if (w_tkn_q) begin
      if (w_old != 2'b11) w_new = w_old + 2'b01;
    end else begin
      if (w_old != 2'b00) w_new = w_old - 2'b01;
    end
  end

  assign o_bht_ridx   = pred_rd ? pred_idx : (pop ? head_idx : ridx_q);
  assign o_bht_we     = i_reset_n & (~run | w_we);
  assign o_bht_widx   = run ? w_idx_q : init_cnt_q;
  assign o_bht_wdata  = run ? w_new : CNT_INIT;
  assign o_busy       = ~run;
  assign o_ghr        = ghr_q;
  assign o_pred_valid = pend_q;
  assign o_pred_taken = pend_q & ~pend_init_q & i_bht_rdata[1];
  assign o_pred_ghr   = pred_ghr_q;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    ridx_d       = o_bht_ridx;
    pend_d       = i_pred_req;
    pend_init_d  = ~run;
    pred_ghr_d   = ghr_q;
    fifo_idx_d   = fifo_idx_q;
    fifo_tkn_d   = fifo_tkn_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
    w_vld_d      = pop;
    w_idx_d      = head_idx;
    w_tkn_d      = fifo_tkn_q[rd_ptr_q];
    w_fwd_d      = pop & w_we & (head_idx == w_idx_q);
    last_wdata_d = w_we ? w_new : last_wdata_q;
    ghr_d        = ghr_q;

    if (!run) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) state_d = ST_RUN;
    end
    if (push) begin
      fifo_idx_d[wr_ptr_q] = upd_idx;
      fifo_tkn_d[wr_ptr_q] = i_upd_taken;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // A resolved mispredict rebuilds history from the branch's own snapshot and wins over speculation.
    if (i_upd_valid && i_upd_mispred) ghr_d = {i_upd_ghr[IDX_W-2:0], i_upd_taken};
    else if (pend_q)                  ghr_d = {ghr_q[IDX_W-2:0], o_pred_taken};

    if (i_flush) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
      pend_d     = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      w_vld_d    = 1'b0;
      w_fwd_d    = 1'b0;
      ghr_d      = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      ghr_q        <= '0;
      ridx_q       <= '0;
      pred_ghr_q   <= '0;
      pend_q       <= 1'b0;
      pend_init_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_idx_q[i] <= '0;
      fifo_tkn_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      w_vld_q      <= 1'b0;
      w_tkn_q      <= 1'b0;
      w_fwd_q      <= 1'b0;
      w_idx_q      <= '0;
      last_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      ghr_q        <= ghr_d;
      ridx_q       <= ridx_d;
      pred_ghr_q   <= pred_ghr_d;
      pend_q       <= pend_d;
      pend_init_q  <= pend_init_d;
      fifo_idx_q   <= fifo_idx_d;
      fifo_tkn_q   <= fifo_tkn_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      w_vld_q      <= w_vld_d;
      w_tkn_q      <= w_tkn_d;
      w_fwd_q      <= w_fwd_d;
      w_idx_q      <= w_idx_d;
      last_wdata_q <= last_wdata_d;
    end
  end
endmodule

// File: tb/tb_bht_port_scheduler.sv
// Scoreboard bench for bht_port_scheduler: a table/queue reference model predicts responses and
// counter writes; a negedge monitor compares them against what the scheduler presents.
module tb_bht_port_scheduler;
  localparam int IDX_W = 10;
  localparam int N     = 1 << IDX_W;
  localparam int DEPTH = 4;

  logic             i_clk = 1'b0, i_reset_n = 1'b0, i_flush = 1'b0;
  logic             i_pred_req = 1'b0, i_upd_valid = 1'b0, i_upd_taken = 1'b0, i_upd_mispred = 1'b0;
  logic [31:0]      i_pred_pc = '0, i_upd_pc = '0;
  logic [IDX_W-1:0] i_upd_ghr = '0;
  logic             o_pred_valid, o_pred_taken, o_upd_ready, o_busy, o_bht_we;
  logic [IDX_W-1:0] o_pred_ghr, o_ghr, o_bht_ridx, o_bht_widx;
  logic [1:0]       i_bht_rdata, o_bht_wdata;

  always #5 i_clk = ~i_clk;

  bht_port_scheduler #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .CNT_INIT(2'b01)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_pred_req(i_pred_req), .i_pred_pc(i_pred_pc),
    .o_pred_valid(o_pred_valid), .o_pred_taken(o_pred_taken), .o_pred_ghr(o_pred_ghr), .o_ghr(o_ghr),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_ghr(i_upd_ghr),
    .i_upd_taken(i_upd_taken), .i_upd_mispred(i_upd_mispred), .o_upd_ready(o_upd_ready),
    .o_busy(o_busy), .o_bht_ridx(o_bht_ridx), .i_bht_rdata(i_bht_rdata),
    .o_bht_we(o_bht_we), .o_bht_widx(o_bht_widx), .o_bht_wdata(o_bht_wdata)
  );

  // BHT RAM: synchronous read of the pre-write contents, one-cycle latency.
  logic [1:0] ram [N];
  always @(posedge i_clk) begin
    if (o_bht_we) ram[o_bht_widx] <= o_bht_wdata;
    i_bht_rdata <= ram[o_bht_ridx];
  end

  typedef struct { logic t; logic [IDX_W-1:0] g; } pred_t;
  typedef struct { logic [IDX_W-1:0] idx; logic [1:0] d; } wr_t;
  pred_t pq[$];
  wr_t   wq[$];

  int total = 0, bad = 0;
  int init_seen = 0;

  // Reference state: counter table in acceptance order, outstanding writes per entry, queue occupancy.
  logic [1:0]       m_bht [N];
  int               pend [N];
  bit               m_run = 1'b0, m_rv = 1'b0, m_rt = 1'b0;
  int               m_left = N, m_cnt = 0;
  logic [IDX_W-1:0] m_ghr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin m_bht[i] = 2'b01; pend[i] = 0; end
  endtask

  pred_t mon_p;
  wr_t   mon_w;
  always @(negedge i_clk) if (i_reset_n) begin
    if (o_pred_valid) begin
      if (pq.size() == 0) begin
        total++; bad++;
        $display("FAIL pred_extra act=valid exp=none at %0t", $time);
      end else begin
        mon_p = pq.pop_front();
        chk("pred_taken", 32'(o_pred_taken), 32'(mon_p.t));
        chk("pred_ghr", 32'(o_pred_ghr), 32'(mon_p.g));
      end
    end
    if (i_flush) init_seen = 0;
    else if (o_bht_we && o_busy) begin
      chk("init_widx", 32'(o_bht_widx), 32'(init_seen));
      chk("init_wdata", 32'(o_bht_wdata), 32'd1);
      init_seen++;
    end else if (o_bht_we) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_extra act=idx%0h exp=none at %0t", o_bht_widx, $time);
      end else begin
        mon_w = wq.pop_front();
        chk("wr_idx", 32'(o_bht_widx), 32'(mon_w.idx));
        chk("wr_data", 32'(o_bht_wdata), 32'(mon_w.d));
        pend[mon_w.idx]--;
      end
    end
  end

  // One clock cycle: drive inputs, advance the model, then check registered state after the edge.
  task automatic cyc(input bit pred, input logic [31:0] ppc, input bit uv, input logic [31:0] upc,
                     input logic [IDX_W-1:0] ug, input bit ut, input bit um, input bit fl, output bit acc);
    logic [IDX_W-1:0] pi, ui;
    logic [1:0] c;
    bit rdy, pr, pop;
    pred_t p;
    wr_t w;
    rdy = m_run && (m_cnt < DEPTH);
    chk("upd_ready", 32'(o_upd_ready), 32'(rdy));
    chk("busy", 32'(o_busy), 32'(!m_run));
    pi = ppc[IDX_W+1:2] ^ m_ghr;
    if (pred && m_run && pend[pi] != 0) pred = 1'b0;  // entry has an unwritten update: skip this read
    pr  = pred && !fl;
    p.t = 1'b0;
    p.g = m_ghr;
    if (pr) begin
      if (m_run) p.t = m_bht[pi][1];
      pq.push_back(p);
    end
    acc = uv && rdy && !fl;
    if (acc) begin
      ui = upc[IDX_W+1:2] ^ ug;
      c  = m_bht[ui];
      if (ut) c = (c == 2'd3) ? 2'd3 : c + 2'd1;
      else    c = (c == 2'd0) ? 2'd0 : c - 2'd1;
      m_bht[ui] = c;
      pend[ui]++;
      w.idx = ui; w.d = c;
      wq.push_back(w);
    end
    pop   = m_run && !pred && (m_cnt > 0) && !fl;
    m_cnt = m_cnt + int'(acc) - int'(pop);
    if (fl)            m_ghr = '0;
    else if (uv && um) m_ghr = {ug[IDX_W-2:0], ut};
    else if (m_rv)     m_ghr = {m_ghr[IDX_W-2:0], m_rt};
    m_rv = pr;
    m_rt = p.t;
    if (fl) begin
      m_run = 1'b0; m_left = N; m_cnt = 0; wq.delete(); model_clear();
    end else if (!m_run) begin
      m_left--;
      if (m_left == 0) m_run = 1'b1;
    end
    i_pred_req = pred; i_pred_pc = ppc; i_upd_valid = uv; i_upd_pc = upc;
    i_upd_ghr = ug; i_upd_taken = ut; i_upd_mispred = um; i_flush = fl;
    @(posedge i_clk); #1;
    chk("ghr", 32'(o_ghr), 32'(m_ghr));
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, a);
  endtask

  initial begin
    bit a;
    int k, wes;
    model_clear();
    i_pred_req = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_we", 32'(o_bht_we), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd1);
    chk("rst_ready", 32'(o_upd_ready), 32'd0);
    chk("rst_pred_valid", 32'(o_pred_valid), 32'd0);
    chk("rst_ghr", 32'(o_ghr), 32'd0);
    chk("rst_ridx", 32'(o_bht_ridx), 32'd0);
    i_reset_n = 1'b1;

    // Init sweep after reset
    idle(N);
    chk("init_count", 32'(init_seen), 32'(N));
    chk("init_done_busy", 32'(o_busy), 32'd0);
    chk("init_done_ready", 32'(o_upd_ready), 32'd1);

    // Single update: read next cycle, write the cycle after
    cyc(1'b0, '0, 1'b1, 32'h40, '0, 1'b1, 1'b0, 1'b0, a);
    chk("t2_ridx", 32'(o_bht_ridx), 32'h010);
    idle(1);
    chk("t2_we", 32'(o_bht_we), 32'd1);
    chk("t2_widx", 32'(o_bht_widx), 32'h010);
    chk("t2_wdata", 32'(o_bht_wdata), 32'd2);
    idle(2);

    // Back-to-back same-index updates: forwarding and saturation
    repeat (2) cyc(1'b0, '0, 1'b1, 32'h44, '0, 1'b1, 1'b0, 1'b0, a);
    chk("t3_w1", 32'({o_bht_we, o_bht_widx, o_bht_wdata}), 32'({1'b1, 10'h011, 2'd2}));
    cyc(1'b0, '0, 1'b1, 32'h44, '0, 1'b1, 1'b0, 1'b0, a);
    chk("t3_w2", 32'({o_bht_we, o_bht_widx, o_bht_wdata}), 32'({1'b1, 10'h011, 2'd3}));
    idle(1);
    chk("t3_w3", 32'({o_bht_we, o_bht_widx, o_bht_wdata}), 32'({1'b1, 10'h011, 2'd3}));
    idle(3);

    // Prediction, speculative shift, then mispredict override in a response cycle
    cyc(1'b1, 32'h40, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, a);
    chk("t4_valid", 32'(o_pred_valid), 32'd1);
    chk("t4_taken", 32'(o_pred_taken), 32'd1);
    chk("t4_pred_ghr", 32'(o_pred_ghr), 32'd0);
    idle(1);
    chk("t4_ghr_shift", 32'(o_ghr), 32'h001);
    cyc(1'b1, 32'h40, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, a);
    cyc(1'b0, '0, 1'b1, 32'h80, 10'h001, 1'b0, 1'b1, 1'b0, a);
    chk("t4_ghr_mispred", 32'(o_ghr), 32'h002);
    idle(3);

    // Prediction stream starves the queue until it fills
    k = 0; wes = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'h1000, k < 5, 32'h300 + 32'(k * 4), '0, 1'b1, 1'b0, 1'b0, a);
      k += int'(a);
      wes += int'(o_bht_we);
    end
    chk("t5_hold_writes", 32'(wes), 32'd0);
    chk("t5_accepted", 32'(k), 32'd4);
    chk("t5_ready_low", 32'(o_upd_ready), 32'd0);
    wes = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, k < 5, 32'h300 + 32'(k * 4), '0, 1'b1, 1'b0, 1'b0, a);
      k += int'(a);
      wes += int'(o_bht_we);
    end
    chk("t5_release_burst", 32'(wes), 32'd5);
    chk("t5_fifth", 32'(k), 32'd5);
    idle(4);

    // Flush with queued updates
    k = 0;
    while (k < 2) begin
      cyc(1'b1, 32'h1000, 1'b1, 32'h500 + 32'(k * 4), '0, 1'b0, 1'b0, 1'b0, a);
      k += int'(a);
    end
    cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
    chk("t6_we", 32'(o_bht_we), 32'd1);
    chk("t6_widx", 32'(o_bht_widx), 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd1);
    chk("t6_ghr", 32'(o_ghr), 32'd0);
    idle(N);
    chk("t6_init_count", 32'(init_seen), 32'(N));

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ppc, upc;
      ppc = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15) << 2) : $urandom;
      upc = 32'($urandom_range(0, 7) << 2) | (32'($urandom) & 32'hffff_f000);
      cyc($urandom_range(0, 1) == 1, ppc, $urandom_range(0, 1) == 1, upc,
          IDX_W'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 4) == 0, $urandom_range(0, 1999) == 0, a);
    end
    idle(20);
    if (!m_run) idle(N);
    chk("end_wq_empty", 32'(wq.size()), 32'd0);
    chk("end_pq_empty", 32'(pq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
